// File: rtl/motor_pkg.sv
// Shared codes for the line-follower motor path:
// FSM modes, H-bridge directions and tracker states.
package motor_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE     = 3'd0,
    MODE_STRAIGHT = 3'd1,
    MODE_STEER_L  = 3'd2,
    MODE_STEER_R  = 3'd3,
    MODE_SEARCH   = 3'd4,
    MODE_STOP     = 3'd5
  } mode_e;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_COAST = 2'b00;

  localparam logic [1:0] TRK_ON     = 2'b11;
  localparam logic [1:0] TRK_VEER_R = 2'b10;
  localparam logic [1:0] TRK_VEER_L = 2'b01;
  localparam logic [1:0] TRK_OFF    = 2'b00;

  // Steer against the veer; losing the line from a stop stays stopped.
  function automatic mode_e trk_mode(
    input logic [1:0] trk
  );
    mode_e m;
    unique case (trk)
      TRK_ON:     m = MODE_STRAIGHT;
      TRK_VEER_R: m = MODE_STEER_L;
      TRK_VEER_L: m = MODE_STEER_R;
      default:    m = MODE_STOP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pwm_ramp_channel.sv
// One motor channel: per-period duty/direction ramp
// and registered PWM compare against the shared counter.
module pwm_ramp_channel
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD = 1024,
  parameter int DUTY_STEP  = 32,
  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1,
  localparam int DW = $clog2(PWM_PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] pwm_cnt,
  input  logic          wrap,
  input  logic [1:0]    target_dir,
  input  logic [DW-1:0] target_duty,
  output logic          pwm,
  output logic [1:0]    dir
);

  localparam logic [DW-1:0] STEP = DW'(DUTY_STEP);

  logic [DW-1:0] duty;
  logic [DW-1:0] duty_nxt;
  logic [1:0]    dir_nxt;

  // Direction may only flip once the duty has drained to zero.
  always_comb begin
    duty_nxt = duty;
    dir_nxt  = dir;
    if (target_dir == dir || duty == '0) begin
      dir_nxt = target_dir;
      if (duty < target_duty)
        duty_nxt = (target_duty - duty > STEP) ?
                   duty + STEP : target_duty;
      else
        duty_nxt = (duty - target_duty > STEP) ?
                   duty - STEP : target_duty;
    end else begin
      duty_nxt = (duty > STEP) ? duty - STEP : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
      dir  <= DIR_COAST;
      pwm  <= 1'b0;
    end else begin
      pwm <= DW'(pwm_cnt) < duty;
      if (wrap) begin
        duty <= duty_nxt;
        dir  <= dir_nxt;
      end
    end
  end

endmodule

// File: rtl/motor_drive_ctrl.sv
// Line-follower motor controller: tracker debounce,
// steer/search FSM and two ramped PWM channels.
module motor_drive_ctrl
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD     = 1024,
  parameter int DEBOUNCE       = 16,
  parameter int DUTY_FAST      = 768,
  parameter int DUTY_SLOW      = 256,
  parameter int DUTY_STEP      = 32,
  parameter int SEARCH_TIMEOUT = 1 << 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] state,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic [1:0] left_dir,
  output logic [1:0] right_dir,
  output logic [2:0] mode
);

  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int BW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int SW = (SEARCH_TIMEOUT > 1) ?
                      $clog2(SEARCH_TIMEOUT) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(PWM_PERIOD - 1);
  localparam logic [BW-1:0] DB_LAST   = BW'(DEBOUNCE - 1);
  localparam logic [SW-1:0] SRCH_LAST = SW'(SEARCH_TIMEOUT - 1);
  localparam logic [DW-1:0] FAST      = DW'(DUTY_FAST);
  localparam logic [DW-1:0] SLOW      = DW'(DUTY_SLOW);

  logic [1:0]    cand;
  logic [1:0]    stable;
  logic [BW-1:0] db_cnt;
  mode_e         mode_q;
  mode_e         mode_nxt;
  logic          last_r;
  logic [SW-1:0] srch_cnt;
  logic [CW-1:0] pwm_cnt;
  logic          wrap;
  logic [1:0]    l_dir;
  logic [1:0]    r_dir;
  logic [DW-1:0] l_duty;
  logic [DW-1:0] r_duty;

  assign wrap = (pwm_cnt == CNT_LAST);
  assign mode = mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand   <= TRK_ON;
      stable <= TRK_ON;
      db_cnt <= '0;
    end else begin
      if (state != cand) begin
        cand   <= state;
        db_cnt <= '0;
      end else if (db_cnt != DB_LAST) begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (db_cnt == DB_LAST)
        stable <= cand;
    end
  end

  always_comb begin
    mode_nxt = mode_q;
    unique case (mode_q)
      MODE_IDLE, MODE_STOP:
        mode_nxt = trk_mode(stable);
      MODE_STRAIGHT, MODE_STEER_L, MODE_STEER_R:
        mode_nxt = (stable == TRK_OFF) ?
                   MODE_SEARCH : trk_mode(stable);
      MODE_SEARCH:
        if (stable != TRK_OFF)
          mode_nxt = trk_mode(stable);
        else if (srch_cnt == SRCH_LAST)
          mode_nxt = MODE_STOP;
      default:
        mode_nxt = MODE_IDLE;
    endcase
    if (!en)
      mode_nxt = MODE_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_IDLE;
      last_r   <= 1'b0;
      srch_cnt <= '0;
      pwm_cnt  <= '0;
    end else begin
      mode_q  <= mode_nxt;
      pwm_cnt <= wrap ? '0 : pwm_cnt + 1'b1;
      if (mode_nxt == MODE_STEER_L)
        last_r <= 1'b0;
      else if (mode_nxt == MODE_STEER_R)
        last_r <= 1'b1;
      if (mode_q != MODE_SEARCH)
        srch_cnt <= '0;
      else if (srch_cnt != SRCH_LAST)
        srch_cnt <= srch_cnt + 1'b1;
    end
  end

  // Spin toward the side the line was last seen on.
  always_comb begin
    l_dir  = DIR_COAST;
    r_dir  = DIR_COAST;
    l_duty = '0;
    r_duty = '0;
    unique case (1'b1)
      mode_q == MODE_STRAIGHT: begin
        l_dir = DIR_FWD; l_duty = FAST;
        r_dir = DIR_FWD; r_duty = FAST;
      end
      mode_q == MODE_STEER_L: begin
        l_dir = DIR_FWD; l_duty = SLOW;
        r_dir = DIR_FWD; r_duty = FAST;
      end
      mode_q == MODE_STEER_R: begin
        l_dir = DIR_FWD; l_duty = FAST;
        r_dir = DIR_FWD; r_duty = SLOW;
      end
      mode_q == MODE_SEARCH && !last_r: begin
        l_dir = DIR_REV; l_duty = SLOW;
        r_dir = DIR_FWD; r_duty = SLOW;
      end
      mode_q == MODE_SEARCH && last_r: begin
        l_dir = DIR_FWD; l_duty = SLOW;
        r_dir = DIR_REV; r_duty = SLOW;
      end
      default: ;
    endcase
  end

  pwm_ramp_channel #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_STEP  (DUTY_STEP)
  ) u_left (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_cnt     (pwm_cnt),
    .wrap        (wrap),
    .target_dir  (l_dir),
    .target_duty (l_duty),
    .pwm         (left_pwm),
    .dir         (left_dir)
  );

  pwm_ramp_channel #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_STEP  (DUTY_STEP)
  ) u_right (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_cnt     (pwm_cnt),
    .wrap        (wrap),
    .target_dir  (r_dir),
    .target_duty (r_duty),
    .pwm         (right_pwm),
    .dir         (right_dir)
  );

endmodule
